// File: rtl/e_mdu.sv
// e_mdu: E-stage multiply/divide unit. Owns HI/LO, runs mult/div with a
// fixed busy latency, and commits the precomputed result on the last busy edge.
module e_mdu #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  E_MDUOp,
  input  logic [31:0] E_A,
  input  logic [31:0] E_B,
  output logic        start,
  output logic        busy,
  output logic [31:0] HI,
  output logic [31:0] LO,
  output logic [31:0] E_MDURead
);

  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MTHI  = 4'd5;
  localparam logic [3:0] OP_MTLO  = 4'd6;
  localparam logic [3:0] OP_MFHI  = 4'd7;
  localparam logic [3:0] OP_MFLO  = 4'd8;

  typedef enum logic {IDLE, BUSY} stateT;

  stateT       state, stateNext;
  logic [31:0] counter, counterNext;
  logic [31:0] hiReg, hiNext, loReg, loNext;
  logic [31:0] tHi, tHiNext, tLo, tLoNext;

  // Arithmetic results for the op currently in E.
  logic [63:0] prodS, prodU;
  logic        divZero;
  logic [31:0] safeB, magA, magB;
  logic [31:0] quoU, remU, quoM, remM, quoS, remS;

  assign prodS = {{32{E_A[31]}}, E_A} * {{32{E_B[31]}}, E_B};
  assign prodU = {32'd0, E_A} * {32'd0, E_B};

  // A zero divisor is replaced by 1 so the dividers never produce x; the
  // result is discarded in that case anyway.
  assign divZero = (E_B == 32'd0);
  assign safeB   = divZero ? 32'd1 : E_B;
  assign quoU    = E_A / safeB;
  assign remU    = E_A % safeB;

  // Signed division via magnitudes: 0x80000000 / -1 wraps to 0x80000000
  // without any overflowing signed operation.
  assign magA = E_A[31]   ? -E_A   : E_A;
  assign magB = safeB[31] ? -safeB : safeB;
  assign quoM = magA / magB;
  assign remM = magA % magB;
  assign quoS = (E_A[31] ^ safeB[31]) ? -quoM : quoM;
  assign remS = E_A[31] ? -remM : remM;

  assign busy      = (state == BUSY);
  assign start     = (E_MDUOp >= OP_MULT) && (E_MDUOp <= OP_DIVU) && (state == IDLE);
  assign HI        = hiReg;
  assign LO        = loReg;
  assign E_MDURead = (E_MDUOp == OP_MFHI) ? hiReg :
                     (E_MDUOp == OP_MFLO) ? loReg : 32'd0;

  // Next-state: accept ops when idle, count down and commit when busy.
  always_comb begin
    stateNext   = state;
    counterNext = counter;
    hiNext      = hiReg;
    loNext      = loReg;
    tHiNext     = tHi;
    tLoNext     = tLo;
    case (state)
      IDLE: begin
        if (start) begin
          stateNext = BUSY;
          case (E_MDUOp)
            OP_MULT: begin
              tHiNext     = prodS[63:32];
              tLoNext     = prodS[31:0];
              counterNext = 32'(MULT_CYCLES);
            end
            OP_MULTU: begin
              tHiNext     = prodU[63:32];
              tLoNext     = prodU[31:0];
              counterNext = 32'(MULT_CYCLES);
            end
            OP_DIV: begin
              tHiNext     = divZero ? hiReg : remS;
              tLoNext     = divZero ? loReg : quoS;
              counterNext = 32'(DIV_CYCLES);
            end
            default: begin
              tHiNext     = divZero ? hiReg : remU;
              tLoNext     = divZero ? loReg : quoU;
              counterNext = 32'(DIV_CYCLES);
            end
          endcase
        end else if (E_MDUOp == OP_MTHI) begin
          hiNext = E_A;
        end else if (E_MDUOp == OP_MTLO) begin
          loNext = E_A;
        end
      end
      BUSY: begin
        counterNext = counter - 32'd1;
        if (counter == 32'd1) begin
          hiNext    = tHi;
          loNext    = tLo;
          stateNext = IDLE;
        end
      end
      default: stateNext = IDLE;
    endcase
  end

  // State registers; active-low synchronous reset aborts any operation.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state   <= IDLE;
      counter <= 32'd0;
      hiReg   <= 32'd0;
      loReg   <= 32'd0;
      tHi     <= 32'd0;
      tLo     <= 32'd0;
    end else begin
      state   <= stateNext;
      counter <= counterNext;
      hiReg   <= hiNext;
      loReg   <= loNext;
      tHi     <= tHiNext;
      tLo     <= tLoNext;
    end
  end

endmodule

// File: tb/tb_e_mdu.sv
// tb_e_mdu: directed and random checks of e_mdu against a plain-arithmetic model.
module tb_e_mdu;

  localparam int MC = 5;
  localparam int DC = 10;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  E_MDUOp;
  logic [31:0] E_A, E_B;
  logic        start, busy;
  logic [31:0] HI, LO, E_MDURead;

  int compared   = 0;
  int mismatched = 0;

  // Reference architectural state.
  logic [31:0] mHi, mLo;

  e_mdu #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
    .clk(clk), .reset(reset), .E_MDUOp(E_MDUOp), .E_A(E_A), .E_B(E_B),
    .start(start), .busy(busy), .HI(HI), .LO(LO), .E_MDURead(E_MDURead)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Issue one op at the current negedge (cycle 0) and follow it to completion.
  task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] p;
    longint      sa, sb, q, r;
    logic [31:0] eh, el;
    int          n;
    eh = mHi; el = mLo; n = 0;
    E_MDUOp = op; E_A = a; E_B = b;
    #1;
    case (op)
      4'd1: begin
        p = 64'(longint'($signed(a)) * longint'($signed(b)));
        eh = p[63:32]; el = p[31:0]; n = MC;
      end
      4'd2: begin
        p = 64'(a) * 64'(b);
        eh = p[63:32]; el = p[31:0]; n = MC;
      end
      4'd3: begin
        if (b != 0) begin
          sa = longint'($signed(a)); sb = longint'($signed(b));
          q = sa / sb; r = sa % sb;
          el = q[31:0]; eh = r[31:0];
        end
        n = DC;
      end
      4'd4: begin
        if (b != 0) begin el = a / b; eh = a % b; end
        n = DC;
      end
      default: n = 0;
    endcase
    $display("op=%0d A=%h B=%h expHI=%h expLO=%h", op, a, b, eh, el);
    if (n > 0) begin
      check("start_c0", {31'd0, start}, 32'd1);
      check("busy_c0", {31'd0, busy}, 32'd0);
      check("read_c0", E_MDURead, 32'd0);
      @(negedge clk);
      E_MDUOp = 4'd0;
      for (int i = 1; i <= n; i++) begin
        check("busy_cN", {31'd0, busy}, 32'd1);
        check("hi_hold", HI, mHi);
        check("lo_hold", LO, mLo);
        @(negedge clk);
      end
      mHi = eh; mLo = el;
      check("busy_done", {31'd0, busy}, 32'd0);
      check("hi_commit", HI, mHi);
      check("lo_commit", LO, mLo);
    end else begin
      check("start_nop", {31'd0, start}, 32'd0);
      if (op == 4'd7)      check("mfhi", E_MDURead, mHi);
      else if (op == 4'd8) check("mflo", E_MDURead, mLo);
      else                 check("read_zero", E_MDURead, 32'd0);
      if (op == 4'd5) mHi = a;
      if (op == 4'd6) mLo = a;
      @(negedge clk);
      E_MDUOp = 4'd0;
      check("busy_idle", {31'd0, busy}, 32'd0);
      check("hi_after", HI, mHi);
      check("lo_after", LO, mLo);
    end
  endtask

  initial begin
    logic [3:0]  op;
    logic [31:0] a, b;
    reset = 1'b0; E_MDUOp = 4'd5; E_A = 32'hDEAD_BEEF; E_B = 32'd0;
    mHi = 0; mLo = 0;
    repeat (3) @(negedge clk);
    // mthi held during reset must not write HI.
    check("rst_hi", HI, 32'd0);
    check("rst_lo", LO, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    E_MDUOp = 4'd0;
    reset = 1'b1;

    issue(4'd1, 32'hFFFF_FFFF, 32'h0000_0002);
    issue(4'd1, 32'h0000_0003, 32'h0000_0004);   // back-to-back mult
    issue(4'd2, 32'hFFFF_FFFF, 32'h0000_0002);
    issue(4'd3, 32'hFFFF_FFF9, 32'h0000_0002);
    issue(4'd4, 32'hFFFF_FFF9, 32'h0000_0002);
    issue(4'd3, 32'h8000_0000, 32'hFFFF_FFFF);
    issue(4'd5, 32'h0000_1234, 32'd0);
    issue(4'd6, 32'h0000_5678, 32'd0);
    issue(4'd3, 32'h0000_0064, 32'd0);
    issue(4'd4, 32'h0000_0064, 32'd0);
    issue(4'd6, 32'h0000_ABCD, 32'd0);
    issue(4'd8, 32'd0, 32'd0);
    issue(4'd7, 32'd0, 32'd0);
    issue(4'd12, 32'h1111_1111, 32'h2222_2222);

    // Reset in cycle 4 of a div: aborted result never appears.
    E_MDUOp = 4'd3; E_A = 32'd1000; E_B = 32'd7;
    $display("op=3 A=%h B=%h reset in cycle 4", E_A, E_B);
    @(negedge clk); E_MDUOp = 4'd0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk); reset = 1'b1;
    mHi = 0; mLo = 0;
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_hi", HI, 32'd0);
    check("abort_lo", LO, 32'd0);
    repeat (DC) @(negedge clk);
    check("abort_hi_late", HI, 32'd0);
    check("abort_lo_late", LO, 32'd0);
    issue(4'd1, 32'h0001_0000, 32'hFFFF_0000);

    // Random ops with occasional zero divisors and the signed overflow case.
    for (int k = 0; k < 60; k++) begin
      op = 4'($urandom_range(0, 15));
      a  = $urandom;
      b  = $urandom;
      if ((op == 4'd3 || op == 4'd4) && $urandom_range(0, 3) == 0) b = 32'd0;
      if (op == 4'd3 && $urandom_range(0, 7) == 0) begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
      if ($urandom_range(0, 3) == 0) a = a >> $urandom_range(0, 31);
      issue(op, a, b);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
